// File: rtl/riscv_core_pkg.sv
// Shared opcodes, FSM states and instruction field positions for the N-bit multicycle core.
package riscv_core_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_ADD  = 4'h1;
  localparam logic [3:0] OP_SUB  = 4'h2;
  localparam logic [3:0] OP_AND  = 4'h3;
  localparam logic [3:0] OP_OR   = 4'h4;
  localparam logic [3:0] OP_XOR  = 4'h5;
  localparam logic [3:0] OP_ADDI = 4'h6;
  localparam logic [3:0] OP_LI   = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_MUL  = 4'hA;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RD_MSB  = 11;
  localparam int RD_LSB  = 8;
  localparam int RS1_MSB = 7;
  localparam int RS1_LSB = 4;
  localparam int RS2_MSB = 3;
  localparam int RS2_LSB = 0;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_WB     = 2'd2,
    ST_HALTED = 2'd3
  } state_e;

endpackage

// File: rtl/riscv_core_regfile.sv
// NREGS x DATA_W register file: two async reads, one sync write, R0 and indices >= NREGS read as 0.
module riscv_core_regfile #(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_i,
  input  logic [3:0]        waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [3:0]        raddr1_i,
  input  logic [3:0]        raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o
);

  // R0 has no storage; only R1..NREGS-1 are real flops.
  logic [NREGS-1:1][DATA_W-1:0] regs_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 1; i < NREGS; i++)
        if (we_i && waddr_i == 4'(i)) regs_q[i] <= wdata_i;
    end
  end

  always_comb begin
    rdata1_o = '0;
    rdata2_o = '0;
    for (int i = 1; i < NREGS; i++) begin
      if (raddr1_i == 4'(i)) rdata1_o = regs_q[i];
      if (raddr2_i == 4'(i)) rdata2_o = regs_q[i];
    end
  end

endmodule

// File: rtl/riscv_nbit_multicycle_core.sv
// N-bit multicycle core: FETCH -> EXEC -> WB, 3 cycles per instruction, HALT parks in ST_HALTED.
// Optional multiplier for opcode A is enabled by defining RISCV_CORE_MUL_EN.
module riscv_nbit_multicycle_core
  import riscv_core_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int NREGS  = 8,
  parameter int IMEM_D = 32,
  localparam int PC_W  = $clog2(IMEM_D)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              imem_we,
  input  logic [PC_W-1:0]   imem_waddr,
  input  logic [15:0]       imem_wdata,
  output logic [PC_W-1:0]   pc,
  output logic [DATA_W-1:0] result,
  output logic              halted,
  output logic              illegal
);

  logic [15:0]       imem [IMEM_D];
  state_e            state_q;
  logic [15:0]       ir_q;
  logic [PC_W-1:0]   pc_q, npc_q, npc_d;
  logic [DATA_W-1:0] result_q, alu_q, alu_d;
  logic              wr_q, wr_d, ill_d, halted_q, illegal_q;
  logic [DATA_W-1:0] rs1_v, rs2_v, imm;
  logic [PC_W-1:0]   pc_imm;
  logic [3:0]        op, rd, rs1, rs2;

  assign op  = ir_q[OP_MSB:OP_LSB];
  assign rd  = ir_q[RD_MSB:RD_LSB];
  assign rs1 = ir_q[RS1_MSB:RS1_LSB];
  assign rs2 = ir_q[RS2_MSB:RS2_LSB];
  assign imm    = DATA_W'($signed(rs2));
  assign pc_imm = PC_W'($signed(rs2));

  // Not reset: program survives reset; nonblocking write gives read-before-write on fetch.
  always_ff @(posedge clk)
    if (imem_we) imem[imem_waddr] <= imem_wdata;

  // BEQ compares R[rd] with R[rs1], so the second read port is steered to rd.
  riscv_core_regfile #(.DATA_W(DATA_W), .NREGS(NREGS)) u_rf (
    .clk      (clk),
    .reset    (reset),
    .we_i     (state_q == ST_WB && wr_q),
    .waddr_i  (rd),
    .wdata_i  (alu_q),
    .raddr1_i (rs1),
    .raddr2_i ((op == OP_BEQ) ? rd : rs2),
    .rdata1_o (rs1_v),
    .rdata2_o (rs2_v)
  );

  always_comb begin
    alu_d = '0;
    wr_d  = 1'b0;
    ill_d = 1'b0;
    npc_d = pc_q + PC_W'(1);
    case (op)
      OP_NOP, OP_HALT: ;
      OP_ADD:  begin alu_d = rs1_v + rs2_v; wr_d = 1'b1; end
      OP_SUB:  begin alu_d = rs1_v - rs2_v; wr_d = 1'b1; end
      OP_AND:  begin alu_d = rs1_v & rs2_v; wr_d = 1'b1; end
      OP_OR:   begin alu_d = rs1_v | rs2_v; wr_d = 1'b1; end
      OP_XOR:  begin alu_d = rs1_v ^ rs2_v; wr_d = 1'b1; end
      OP_ADDI: begin alu_d = rs1_v + imm;   wr_d = 1'b1; end
      OP_LI:   begin alu_d = imm;           wr_d = 1'b1; end
      OP_BEQ:  if (rs1_v == rs2_v) npc_d = pc_q + pc_imm;
      OP_JMP:  npc_d = pc_q + pc_imm;
`ifdef RISCV_CORE_MUL_EN
      OP_MUL:  begin alu_d = rs1_v * rs2_v; wr_d = 1'b1; end
`endif
      default: ill_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_FETCH;
      ir_q      <= '0;
      pc_q      <= '0;
      npc_q     <= '0;
      alu_q     <= '0;
      wr_q      <= 1'b0;
      result_q  <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
    end else begin
      case (state_q)
        ST_FETCH: begin
          ir_q    <= imem[pc_q];
          state_q <= ST_EXEC;
        end
        ST_EXEC: begin
          if (op == OP_HALT) begin
            halted_q <= 1'b1;
            state_q  <= ST_HALTED;
          end else begin
            alu_q   <= alu_d;
            wr_q    <= wr_d;
            npc_q   <= npc_d;
            if (ill_d) illegal_q <= 1'b1;
            state_q <= ST_WB;
          end
        end
        ST_WB: begin
          if (wr_q) result_q <= alu_q;
          pc_q    <= npc_q;
          state_q <= ST_FETCH;
        end
        default: state_q <= ST_HALTED;
      endcase
    end
  end

  assign pc      = pc_q;
  assign result  = result_q;
  assign halted  = halted_q;
  assign illegal = illegal_q;

endmodule

// File: tb/tb_riscv_nbit_multicycle_core.sv
// Bench for riscv_nbit_multicycle_core: directed programs plus random programs against an ISA-level model.
module tb_riscv_nbit_multicycle_core;

  localparam int DATA_W = 8;
  localparam int NREGS  = 8;
  localparam int IMEM_D = 32;
  localparam int PC_W   = $clog2(IMEM_D);
  localparam int MASK   = (1 << DATA_W) - 1;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              imem_we = 1'b0;
  logic [PC_W-1:0]   imem_waddr = '0;
  logic [15:0]       imem_wdata = '0;
  logic [PC_W-1:0]   pc;
  logic [DATA_W-1:0] result;
  logic              halted, illegal;

  riscv_nbit_multicycle_core #(.DATA_W(DATA_W), .NREGS(NREGS), .IMEM_D(IMEM_D)) dut (
    .clk        (clk),
    .reset      (reset),
    .imem_we    (imem_we),
    .imem_waddr (imem_waddr),
    .imem_wdata (imem_wdata),
    .pc         (pc),
    .result     (result),
    .halted     (halted),
    .illegal    (illegal)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Architectural model state
  logic [15:0] prog  [IMEM_D];
  logic [15:0] m_mem [IMEM_D];
  int m_regs [16];
  int m_pc, m_result;
  bit m_halted, m_illegal;

  function automatic logic [15:0] enc(input int op, input int rd, input int rs1, input int r2);
    logic [15:0] w;
    w = {4'(op), 4'(rd), 4'(rs1), 4'(r2)};
    return w;
  endfunction

  function automatic int rr(input int i);
    return (i == 0 || i >= NREGS) ? 0 : m_regs[i];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 0;
    m_pc = 0; m_result = 0; m_halted = 0; m_illegal = 0;
  endtask

  task automatic model_exec();
    logic [15:0] w;
    int op, rd, a, b, imm, v, npc;
    bit wr;
    if (m_halted) return;
    w   = m_mem[m_pc];
    op  = int'(w[15:12]);
    rd  = int'(w[11:8]);
    a   = rr(int'(w[7:4]));
    b   = rr(int'(w[3:0]));
    imm = (w[3:0] > 4'd7) ? int'(w[3:0]) - 16 : int'(w[3:0]);
    npc = m_pc + 1;
    wr  = 1;
    v   = 0;
    case (op)
      1: v = a + b;
      2: v = a - b;
      3: v = a & b;
      4: v = a | b;
      5: v = a ^ b;
      6: v = a + imm;
      7: v = imm;
      0: wr = 0;
      8: begin wr = 0; if (rr(rd) == a) npc = m_pc + imm; end
      9: begin wr = 0; npc = m_pc + imm; end
      15: begin m_halted = 1; return; end
`ifdef RISCV_CORE_MUL_EN
      10: v = a * b;
`endif
      default: begin wr = 0; m_illegal = 1; end
    endcase
    if (wr) begin
      v = v & MASK;
      m_result = v;
      if (rd != 0 && rd < NREGS) m_regs[rd] = v;
    end
    m_pc = ((npc % IMEM_D) + IMEM_D) % IMEM_D;
  endtask

  task automatic check_arch(input string t);
    chk({t, "_pc"}, 32'(pc), 32'(m_pc));
    chk({t, "_result"}, 32'(result), 32'(m_result));
    chk({t, "_halted"}, 32'(halted), 32'(m_halted));
    chk({t, "_illegal"}, 32'(illegal), 32'(m_illegal));
  endtask

  // Preload prog[] while in reset, then release; entered and left on a falling edge.
  task automatic load();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < IMEM_D; i++) begin
      imem_we = 1'b1; imem_waddr = PC_W'(i); imem_wdata = prog[i];
      @(negedge clk);
    end
    imem_we = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < IMEM_D; i++) m_mem[i] = prog[i];
    check_arch("reset");
  endtask

  // One instruction (3 cycles) with an optional imem write on the fetch edge.
  task automatic step(input bit wr, input int wa, input logic [15:0] wd);
    int pc0, res0;
    bit h0;
    pc0 = m_pc; res0 = m_result; h0 = m_halted;
    imem_we = wr; imem_waddr = PC_W'(wa); imem_wdata = wd;
    @(negedge clk);
    imem_we = 1'b0;
    model_exec();
    if (wr) m_mem[wa] = wd;
    chk("pc_fetch", 32'(pc), 32'(pc0));
    chk("halted_fetch", 32'(halted), 32'(h0));
    @(negedge clk);
    chk("pc_exec", 32'(pc), 32'(pc0));
    chk("result_exec", 32'(result), 32'(res0));
    chk("halted_exec", 32'(halted), 32'(m_halted));
    @(negedge clk);
    check_arch("wb");
  endtask

  task automatic run(input int max_steps);
    int n;
    n = 0;
    while (!m_halted && n < max_steps) begin
      step(0, 0, 16'h0);
      n++;
    end
    step(0, 0, 16'h0);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < IMEM_D; i++) prog[i] = 16'h0000;
  endtask

  initial begin
    // Reset mid-program clears regs, pc, result and sticky illegal
    clear_prog();
    prog[0] = enc(1, 2, 1, 1);
    prog[1] = enc(7, 1, 0, 5);
    prog[2] = enc(11, 0, 0, 0);
    load();
    repeat (3) step(0, 0, 16'h0);
    chk("pre_reset_illegal", 32'(illegal), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    model_reset();
    check_arch("midreset");
    repeat (2) step(0, 0, 16'h0);

    // Arithmetic then HALT at pc 4 (halted on cycle 14)
    clear_prog();
    prog[0] = enc(7, 1, 0, 5);
    prog[1] = enc(7, 2, 0, 13);
    prog[2] = enc(1, 3, 1, 2);
    prog[3] = enc(2, 4, 2, 1);
    prog[4] = enc(15, 0, 0, 0);
    load();
    run(10);
    chk("arith_r4", 32'(result), 32'h0F8);
    chk("arith_pc", 32'(pc), 32'd4);

    // Countdown loop with BEQ/JMP
    clear_prog();
    prog[0] = enc(7, 1, 0, 3);
    prog[1] = enc(6, 1, 1, 15);
    prog[2] = enc(8, 1, 0, 2);
    prog[3] = enc(9, 0, 0, 14);
    prog[4] = enc(15, 0, 0, 0);
    load();
    run(40);
    chk("loop_pc", 32'(pc), 32'd4);

    // pc wrap backward/forward, data wrap, and read-before-write on fetch
    clear_prog();
    prog[0]  = enc(9, 0, 0, 15);
    prog[31] = enc(9, 0, 0, 2);
    prog[1]  = enc(6, 1, 1, 7);
    prog[2]  = enc(9, 0, 0, 15);
    load();
    step(0, 0, 16'h0);
    chk("wrap_pc", 32'(pc), 32'(IMEM_D - 1));
    repeat (80) step(0, 0, 16'h0);
    step(1, m_pc, enc(7, 1, 0, 9));
    step(0, 0, 16'h0);

    // BEQ with zero offset spins on itself
    clear_prog();
    prog[0] = enc(8, 0, 0, 0);
    load();
    repeat (3) step(0, 0, 16'h0);

    // R0 discard, out-of-range reg, illegal opcode
    clear_prog();
    prog[0] = enc(7, 0, 0, 5);
    prog[1] = enc(1, 1, 0, 0);
    prog[2] = enc(7, 1, 0, 4);
    prog[3] = enc(11, 1, 1, 1);
    prog[4] = enc(7, 9, 0, 3);
    prog[5] = enc(1, 2, 9, 9);
    prog[6] = enc(15, 0, 0, 0);
    load();
    run(12);

    // MUL (legal or illegal depending on build)
    clear_prog();
    prog[0] = enc(7, 1, 0, 7);
    prog[1] = enc(7, 2, 0, 6);
    prog[2] = enc(10, 3, 1, 2);
    prog[3] = enc(15, 0, 0, 0);
    load();
    run(8);
`ifdef RISCV_CORE_MUL_EN
    chk("mul_result", 32'(result), 32'h2A);
`else
    chk("mul_result", 32'(result), 32'h06);
    chk("mul_illegal", 32'(illegal), 32'd1);
`endif

    // Random programs with occasional imem writes, often at the fetch address
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < IMEM_D; i++) prog[i] = 16'($urandom);
      load();
      for (int s = 0; s < 50; s++) begin
        if ($urandom_range(0, 3) == 0)
          step(1, ($urandom_range(0, 1) == 1) ? m_pc : int'($urandom_range(0, IMEM_D - 1)),
               16'($urandom));
        else
          step(0, 0, 16'h0);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
